imem_ctrl: RTL and testbench

- Parametrised instruction-memory block that succeeds the fixed 128x16 reset-loaded instruction RAM.
- Adds a program-load write port and a hardware clear sweep after reset.
- Fetch is registered, with a one-cycle-latency valid pulse and a misaligned/out-of-range error flag.
- Sits between the CPU fetch stage (byte address in, instruction out) and the boot/debug loader.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_array.sv | 48 ++++
 rtl/imem_ctrl.sv | 128 ++++++++++++
 tb/tb_imem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types, default widths and parity helper for the instruction memory.
package imem_pkg;

    typedef enum logic [0:0] {
        CLEAR,
        READY
    } imem_state_e;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 128;

    // Even parity over a zero-extended word; callers cast their data to 64 bits.
    function automatic logic calc_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH-word storage, one synchronous write and one synchronous read port, read-before-write.
// Per-word parity bit storage is present only when IMEM_PARITY_EN is defined.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
`ifdef IMEM_PARITY_EN
    input  logic              wpar,
    output logic              rpar,
`endif
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking updates give the old word to a read of the word being written.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            par_mem[waddr] <= wpar;
        end
        if (re) begin
            rpar <= par_mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: post-reset clear sweep, program write port, registered fetch.
// Define IMEM_PARITY_EN to store and check a per-word even-parity bit.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FETCH,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              VALID,
    output logic              ERR,
    input  logic              PWE,
    input  logic [IDX_W-1:0]  PADDR,
    input  logic [DATA_W-1:0] PDATA,
    output logic              BUSY,
    output logic              PAR_ERR
);

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W:0]    DEPTH_P  = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              valid_q, err_q, q_zero_q;

    logic [ADDR_W-2:0] fidx;
    logic              accept, fetch_bad, rd_en;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata, rdata;

    assign fidx = ADDR[ADDR_W-1:1];

    always_comb begin
        accept    = FETCH && (state_q == READY);
        fetch_bad = ADDR[0] || ({1'b0, fidx} >= DEPTH_A);
        rd_en     = accept && !fetch_bad && !RESET;
    end

    // The clear sweep owns the write port; program writes only land once READY.
    always_comb begin
        we    = 1'b0;
        waddr = PADDR;
        wdata = PDATA;
        if (!RESET) begin
            if (state_q == CLEAR) begin
                we    = 1'b1;
                waddr = clr_ptr_q;
                wdata = '0;
            end else if (PWE && ({1'b0, PADDR} < DEPTH_P)) begin
                we = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            q_zero_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            valid_q   <= accept;
            err_q     <= accept && fetch_bad;
            if (accept) begin
                q_zero_q <= fetch_bad;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic wpar, rpar;

    assign wpar = calc_parity(64'(wdata));
`endif

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .CLK    (CLK),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
`ifdef IMEM_PARITY_EN
        .wpar   (wpar),
        .rpar   (rpar),
`endif
        .re     (rd_en),
        .raddr  (fidx[IDX_W-1:0]),
        .rdata  (rdata)
    );

    // The read register holds the last good word; an error or reset masks it to zero.
    assign Q     = q_zero_q ? '0 : rdata;
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign BUSY  = RESET || (state_q == CLEAR);

`ifdef IMEM_PARITY_EN
    assign PAR_ERR = valid_q && !err_q && (calc_parity(64'(rdata)) != rpar);
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: a DEPTH=128 instance driven by a vector table plus
// hand sequences, and a DEPTH=100 instance sharing the inputs for the range checks.
module tb_imem_ctrl;

    logic        CLK;
    logic        RESET;
    logic        FETCH;
    logic [7:0]  ADDR;
    logic        PWE;
    logic [6:0]  PADDR;
    logic [15:0] PDATA;

    logic [15:0] Q, Q100;
    logic        VALID, VALID100, ERR, ERR100, BUSY, BUSY100, PAR_ERR, PAR_ERR100;

    int n_vec  = 0;
    int n_miss = 0;

    imem_ctrl #(
        .DATA_W (16),
        .ADDR_W (8),
        .DEPTH  (128)
    ) u_dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .FETCH   (FETCH),
        .ADDR    (ADDR),
        .Q       (Q),
        .VALID   (VALID),
        .ERR     (ERR),
        .PWE     (PWE),
        .PADDR   (PADDR),
        .PDATA   (PDATA),
        .BUSY    (BUSY),
        .PAR_ERR (PAR_ERR)
    );

    imem_ctrl #(
        .DATA_W (16),
        .ADDR_W (8),
        .DEPTH  (100)
    ) u_dut100 (
        .CLK     (CLK),
        .RESET   (RESET),
        .FETCH   (FETCH),
        .ADDR    (ADDR),
        .Q       (Q100),
        .VALID   (VALID100),
        .ERR     (ERR100),
        .PWE     (PWE),
        .PADDR   (PADDR),
        .PDATA   (PDATA),
        .BUSY    (BUSY100),
        .PAR_ERR (PAR_ERR100)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        fetch;
        logic [7:0]  addr;
        logic        pwe;
        logic [6:0]  paddr;
        logic [15:0] pdata;
        logic        exp_valid;
        logic        exp_err;
        logic        chk_q;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic f, input logic [7:0] a, input logic w,
                                input logic [6:0] pa, input logic [15:0] pd,
                                input logic ev, input logic ee, input logic cq,
                                input logic [15:0] eq);
        vec_t v;
        v.fetch = f;  v.addr = a;  v.pwe = w;  v.paddr = pa;  v.pdata = pd;
        v.exp_valid = ev;  v.exp_err = ee;  v.chk_q = cq;  v.exp_q = eq;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [7:0] a, input logic w,
                         input logic [6:0] pa, input logic [15:0] pd);
        FETCH = f;  ADDR = a;  PWE = w;  PADDR = pa;  PDATA = pd;
    endtask

    // Counts cycles from RESET release until BUSY drops on each instance.
    task automatic sweep(input string nm);
        int   c_a, c_b;
        logic seen;
        c_a  = -1;
        c_b  = -1;
        seen = 1'b0;
        for (int i = 1; i <= 300 && c_a < 0; i++) begin
            step();
            seen = seen | VALID;
            if (c_b < 0 && !BUSY100) c_b = i;
            if (!BUSY) begin
                c_a   = i;
                FETCH = 1'b0;
                PWE   = 1'b0;
            end
        end
        chk({nm, " busy cycles d128"}, 32'(c_a), 32'd128);
        chk({nm, " busy cycles d100"}, 32'(c_b), 32'd100);
        chk({nm, " no valid in sweep"}, 32'(seen), 32'd0);
    endtask

    task automatic chk_fetch(input string nm, input logic ev, input logic ee,
                             input logic [15:0] eq);
        chk({nm, " valid"}, 32'(VALID), 32'(ev));
        chk({nm, " err"},   32'(ERR),   32'(ee));
        chk({nm, " q"},     32'(Q),     32'(eq));
    endtask

    task automatic chk_fetch100(input string nm, input logic ee, input logic [15:0] eq);
        chk({nm, " valid100"}, 32'(VALID100), 32'd1);
        chk({nm, " err100"},   32'(ERR100),   32'(ee));
        chk({nm, " q100"},     32'(Q100),     32'(eq));
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 7'd0, 16'h0000);
        step();
        step();
        chk("reset valid", 32'(VALID), 32'd0);
        chk("reset err", 32'(ERR), 32'd0);
        chk("reset q", 32'(Q), 32'd0);
        chk("reset busy", 32'(BUSY), 32'd1);
        chk("reset par_err", 32'(PAR_ERR), 32'd0);

        RESET = 1'b0;
        sweep("first");

        // Preload word 5, confirm it, then reset and confirm the sweep cleared it.
        drive(1'b0, 8'h00, 1'b1, 7'd5, 16'hABCD);
        step();
        drive(1'b1, 8'h0A, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch("preload w5", 1'b1, 1'b0, 16'hABCD);
        drive(1'b0, 8'h00, 1'b0, 7'd0, 16'h0000);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        sweep("second");
        drive(1'b1, 8'h0A, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch("cleared w5", 1'b1, 1'b0, 16'h0000);

        // Reset together with a fetch, then reset again mid-sweep with FETCH/PWE held.
        drive(1'b1, 8'h0A, 1'b1, 7'd5, 16'h5555);
        RESET = 1'b1;
        step();
        chk("fetch under reset valid", 32'(VALID), 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (VALID) chk("valid during sweep", 32'(VALID), 32'd0);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        sweep("restart");
        drive(1'b1, 8'h0A, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch("pwe ignored in clear", 1'b1, 1'b0, 16'h0000);

        vecs[0]  = mk(1'b0, 8'h00, 1'b1, 7'd3,   16'hF249, 1'b0, 1'b0, 1'b1, 16'h0000);
        vecs[1]  = mk(1'b1, 8'h06, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'hF249);
        vecs[2]  = mk(1'b1, 8'h06, 1'b1, 7'd0,   16'h1000, 1'b1, 1'b0, 1'b1, 16'hF249);
        vecs[3]  = mk(1'b0, 8'h00, 1'b1, 7'd1,   16'h2001, 1'b0, 1'b0, 1'b1, 16'hF249);
        vecs[4]  = mk(1'b0, 8'h00, 1'b1, 7'd2,   16'h3002, 1'b0, 1'b0, 1'b1, 16'hF249);
        vecs[5]  = mk(1'b1, 8'h00, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h1000);
        vecs[6]  = mk(1'b1, 8'h02, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h2001);
        vecs[7]  = mk(1'b1, 8'h04, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h3002);
        vecs[8]  = mk(1'b1, 8'h06, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'hF249);
        vecs[9]  = mk(1'b1, 8'h03, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000);
        vecs[10] = mk(1'b1, 8'h06, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'hF249);
        vecs[11] = mk(1'b0, 8'h00, 1'b0, 7'd0,   16'h0000, 1'b0, 1'b0, 1'b1, 16'hF249);
        vecs[12] = mk(1'b1, 8'hFF, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000);
        vecs[13] = mk(1'b0, 8'h00, 1'b1, 7'd7,   16'h1111, 1'b0, 1'b0, 1'b1, 16'h0000);
        vecs[14] = mk(1'b1, 8'h0E, 1'b1, 7'd7,   16'h2222, 1'b1, 1'b0, 1'b1, 16'h1111);
        vecs[15] = mk(1'b1, 8'h0E, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222);
        vecs[16] = mk(1'b1, 8'hFE, 1'b1, 7'd127, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h0000);
        vecs[17] = mk(1'b1, 8'hFE, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF);
        vecs[18] = mk(1'b1, 8'h01, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000);
        vecs[19] = mk(1'b1, 8'h00, 1'b0, 7'd0,   16'h0000, 1'b1, 1'b0, 1'b1, 16'h1000);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].fetch, vecs[i].addr, vecs[i].pwe, vecs[i].paddr, vecs[i].pdata);
            step();
            chk($sformatf("v%0d valid", i), 32'(VALID), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d err", i), 32'(ERR), 32'(vecs[i].exp_err));
            if (vecs[i].chk_q) chk($sformatf("v%0d q", i), 32'(Q), 32'(vecs[i].exp_q));
            chk($sformatf("v%0d par_err", i), 32'(PAR_ERR), 32'd0);
        end

        // Range checks against the DEPTH=100 instance.
        drive(1'b0, 8'h00, 1'b1, 7'd99, 16'h9999);
        step();
        drive(1'b1, 8'hC6, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch100("idx99", 1'b0, 16'h9999);
        chk_fetch("idx99 d128", 1'b1, 1'b0, 16'h9999);
        drive(1'b1, 8'hD0, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch100("idx104", 1'b1, 16'h0000);
        chk_fetch("idx104 d128", 1'b1, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b1, 7'd110, 16'h6E6E);
        step();
        drive(1'b1, 8'hDC, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch100("idx110", 1'b1, 16'h0000);
        chk_fetch("idx110 d128", 1'b1, 1'b0, 16'h6E6E);
        drive(1'b1, 8'h14, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch100("no alias idx10", 1'b0, 16'h0000);
        drive(1'b1, 8'h5C, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch100("no alias idx46", 1'b0, 16'h0000);
        chk("par_err100 tied", 32'(PAR_ERR100), 32'd0);

`ifdef IMEM_PARITY_EN
        drive(1'b0, 8'h00, 1'b1, 7'd20, 16'h0001);
        step();
        drive(1'b1, 8'h28, 1'b0, 7'd0, 16'h0000);
        step();
        chk("parity clean", 32'(PAR_ERR), 32'd0);
        u_dut.u_array.par_mem[20] = ~u_dut.u_array.par_mem[20];
        step();
        chk_fetch("parity flip", 1'b1, 1'b0, 16'h0001);
        chk("parity flip par_err", 32'(PAR_ERR), 32'd1);
        drive(1'b1, 8'h29, 1'b0, 7'd0, 16'h0000);
        step();
        chk_fetch("parity on err req", 1'b1, 1'b1, 16'h0000);
        chk("par_err on err req", 32'(PAR_ERR), 32'd0);
`endif

        drive(1'b0, 8'h00, 1'b0, 7'd0, 16'h0000);
        step();
        chk("idle valid", 32'(VALID), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
